// File: rtl/ring_seq_pkg.sv
// Shared types and defaults for the ring dwell sequencer.
// Imported by the interface, the peek controller and the top.
package ring_seq_pkg;

  localparam int DATA_W_DEF   = 4;
  localparam int ADDR_W_DEF   = 7;
  localparam int DWELL_W_DEF  = 16;
  localparam int PEEK_TMO_DEF = 255;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DWELL
  } main_state_t;

  typedef enum logic {
    P_IDLE,
    P_WAIT
  } peek_state_t;

endpackage

// File: rtl/ring_dwell_sequencer_if.sv
// Ring buffer consumer bus: sequential pop port plus random-read port.
// master = sequencer side, slave = ring side.
interface ring_dwell_sequencer_if
  import ring_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              ring_ready;
  logic [DATA_W-1:0] ring_dout;
  logic [ADDR_W-1:0] ring_index;
  logic              ring_rd_en;
  logic [ADDR_W-1:0] ring_rand_rd_addr;
  logic              ring_rand_rd_en;
  logic              ring_rand_rd_valid;

  modport master (
    input  ring_ready,
    input  ring_dout,
    input  ring_index,
    input  ring_rand_rd_valid,
    output ring_rd_en,
    output ring_rand_rd_addr,
    output ring_rand_rd_en
  );

  modport slave (
    output ring_ready,
    output ring_dout,
    output ring_index,
    output ring_rand_rd_valid,
    input  ring_rd_en,
    input  ring_rand_rd_addr,
    input  ring_rand_rd_en
  );

endinterface

// File: rtl/ring_peek_ctrl.sv
// Host peek engine on the ring random-read port, with timeout.
// A pop in the same cycle wins; the request waits one cycle.
module ring_peek_ctrl
  import ring_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PEEK_TMO = PEEK_TMO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pop_this_cycle,
  input  logic              peek_req,
  input  logic [ADDR_W-1:0] peek_addr,
  input  logic              rand_rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rand_rd_addr,
  output logic              rand_rd_en,
  output logic              peek_busy,
  output logic              peek_done,
  output logic              peek_err,
  output logic [DATA_W-1:0] peek_data
);

  localparam int TMO_W = $clog2(PEEK_TMO + 1);

  peek_state_t      state;
  peek_state_t      state_nx;
  logic             pend;
  logic             req;
  logic             accept;
  logic             got;
  logic             tmo;
  logic [TMO_W-1:0] tmo_cnt;

  assign req = peek_req | pend;

  always_ff @(posedge clk) begin
    if (rst) state <= P_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    got      = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      P_IDLE: begin
        if (req && !pop_this_cycle) begin
          accept   = 1'b1;
          state_nx = P_WAIT;
        end
      end
      P_WAIT: begin
        if (rand_rd_valid) begin
          got      = 1'b1;
          state_nx = P_IDLE;
        end else if (tmo_cnt == TMO_W'(PEEK_TMO - 1)) begin
          tmo      = 1'b1;
          state_nx = P_IDLE;
        end
      end
      default: state_nx = P_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend         <= 1'b0;
      rand_rd_addr <= '0;
      rand_rd_en   <= 1'b0;
      peek_busy    <= 1'b0;
      peek_done    <= 1'b0;
      peek_err     <= 1'b0;
      peek_data    <= '0;
      tmo_cnt      <= '0;
    end else begin
      pend      <= (state == P_IDLE) & req & pop_this_cycle;
      peek_done <= got | tmo;
      peek_err  <= tmo;
      if (accept) begin
        rand_rd_addr <= peek_addr;
        rand_rd_en   <= 1'b1;
        peek_busy    <= 1'b1;
        tmo_cnt      <= '0;
      end else if (got || tmo) begin
        rand_rd_en <= 1'b0;
        peek_busy  <= 1'b0;
      end else if (state == P_WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (got) peek_data <= rd_data;
    end
  end

endmodule

// File: rtl/ring_dwell_sequencer.sv
// Pops ring entries and dwells on each for dwell_len cycles.
// Host peeks share the ring via ring_peek_ctrl.
module ring_dwell_sequencer
  import ring_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DWELL_W  = DWELL_W_DEF,
  parameter int PEEK_TMO = PEEK_TMO_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DWELL_W-1:0]  dwell_len,
  ring_dwell_sequencer_if.master ring,
  input  logic                peek_req,
  input  logic [ADDR_W-1:0]   peek_addr,
  output logic                peek_busy,
  output logic                peek_done,
  output logic                peek_err,
  output logic [DATA_W-1:0]   peek_data,
  output logic [DATA_W-1:0]   sel_data,
  output logic [ADDR_W-1:0]   sel_index,
  output logic                sel_valid,
  output logic                sel_strobe,
  output logic [15:0]         entry_count
);

  main_state_t       state;
  main_state_t       state_nx;
  logic              pop;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [ADDR_W-1:0] rand_addr;
  logic              rand_en;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // peek_busy covers rand_rd_en, so a pop never overlaps a random read
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nx = FETCH;
      end
      FETCH: begin
        if (ring.ring_ready && !peek_busy) begin
          pop      = 1'b1;
          state_nx = DWELL;
        end else if (!enable) begin
          state_nx = IDLE;
        end
      end
      DWELL: begin
        if (dwell_cnt <= DWELL_W'(1))
          state_nx = enable ? FETCH : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ring.ring_rd_en        = pop;
  assign ring.ring_rand_rd_addr = rand_addr;
  assign ring.ring_rand_rd_en   = rand_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_data    <= '0;
      sel_index   <= '0;
      sel_valid   <= 1'b0;
      sel_strobe  <= 1'b0;
      entry_count <= '0;
      dwell_cnt   <= '0;
    end else begin
      sel_strobe <= pop;
      if (pop) begin
        sel_data    <= ring.ring_dout;
        sel_index   <= ring.ring_index;
        sel_valid   <= 1'b1;
        entry_count <= entry_count + 16'd1;
        dwell_cnt   <= (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
      end else if (state == DWELL) begin
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end
    end
  end

  ring_peek_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .PEEK_TMO (PEEK_TMO)
  ) u_peek (
    .clk            (clk),
    .rst            (rst),
    .pop_this_cycle (pop),
    .peek_req       (peek_req),
    .peek_addr      (peek_addr),
    .rand_rd_valid  (ring.ring_rand_rd_valid),
    .rd_data        (ring.ring_dout),
    .rand_rd_addr   (rand_addr),
    .rand_rd_en     (rand_en),
    .peek_busy      (peek_busy),
    .peek_done      (peek_done),
    .peek_err       (peek_err),
    .peek_data      (peek_data)
  );

endmodule

// File: tb/tb_ring_dwell_sequencer.sv
// Directed bench for ring_dwell_sequencer with a small ring model.
// Inputs change and outputs are sampled on the falling edge.
module tb_ring_dwell_sequencer;
  import ring_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] dwell_len = '0;
  logic        peek_req = 1'b0;
  logic [6:0]  peek_addr = '0;
  logic        peek_busy;
  logic        peek_done;
  logic        peek_err;
  logic [3:0]  peek_data;
  logic [3:0]  sel_data;
  logic [6:0]  sel_index;
  logic        sel_valid;
  logic        sel_strobe;
  logic [15:0] entry_count;

  ring_dwell_sequencer_if rif ();

  ring_dwell_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .dwell_len   (dwell_len),
    .ring        (rif.master),
    .peek_req    (peek_req),
    .peek_addr   (peek_addr),
    .peek_busy   (peek_busy),
    .peek_done   (peek_done),
    .peek_err    (peek_err),
    .peek_data   (peek_data),
    .sel_data    (sel_data),
    .sel_index   (sel_index),
    .sel_valid   (sel_valid),
    .sel_strobe  (sel_strobe),
    .entry_count (entry_count)
  );

  always #5 clk = ~clk;

  // ring model: head pointer, optional re-init, random read valid 3 cycles in
  logic [3:0] mem [128];
  logic [6:0] hd;
  logic       rdy = 1'b0;
  logic       vmode = 1'b0;
  logic       reinit = 1'b0;
  logic [6:0] reinit_val = '0;
  int         vcnt;
  int         pops;
  int         overlap;
  int         bad_rd;
  logic       rvalid;

  assign rvalid = vmode & rif.ring_rand_rd_en & (vcnt == 3);
  assign rif.ring_rand_rd_valid = rvalid;
  assign rif.ring_ready = rdy;
  assign rif.ring_index = hd;
  assign rif.ring_dout = rvalid ? mem[rif.ring_rand_rd_addr] : mem[hd];

  always @(posedge clk) begin
    if (rst) begin
      hd      <= '0;
      vcnt    <= 0;
      pops    <= 0;
      overlap <= 0;
      bad_rd  <= 0;
    end else begin
      if (reinit) hd <= reinit_val;
      else if (rif.ring_rd_en) hd <= hd + 7'd1;
      vcnt <= rif.ring_rand_rd_en ? vcnt + 1 : 0;
      if (rif.ring_rd_en) pops <= pops + 1;
      if (rif.ring_rd_en && rif.ring_rand_rd_en) overlap <= overlap + 1;
      if (rif.ring_rd_en && !rdy) bad_rd <= bad_rd + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_pop(input int lim, output int n);
    n = 0;
    while (!rif.ring_rd_en && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done(input int lim, output int n, output int ecnt,
                           output int bcnt);
    n = 0;
    ecnt = 0;
    bcnt = 0;
    while (!peek_done && n < lim) begin
      if (rif.ring_rand_rd_en) ecnt++;
      if (rif.ring_rd_en && peek_busy) bcnt++;
      tick();
      n++;
    end
  endtask

  logic [3:0] t1d [3] = '{4'h3, 4'h7, 4'hA};

  initial begin
    int n;
    int ecnt;
    int bcnt;
    int p0;
    logic [3:0] ed;
    logic [6:0] ei;

    for (int i = 0; i < 128; i++) mem[i] = 4'((i * 5 + 1) & 15);
    mem[0]  = 4'h3;
    mem[1]  = 4'h7;
    mem[2]  = 4'hA;
    mem[5]  = 4'h9;
    mem[17] = 4'hC;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", sel_valid, 0);
    chk("rst_count", entry_count, 0);
    chk("rst_data", sel_data, 0);
    chk("rst_strobe", sel_strobe, 0);
    chk("rst_rd_en", rif.ring_rd_en, 0);
    chk("rst_rand_en", rif.ring_rand_rd_en, 0);
    chk("rst_busy", peek_busy, 0);
    chk("rst_done", peek_done, 0);
    rst = 1'b0;

    // dwell 4: three pops five cycles apart
    enable = 1'b1;
    dwell_len = 16'd4;
    rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_pop(20, n);
      if (k > 0) chk("t1_gap", n, 4);
      chk("t1_rd_en", rif.ring_rd_en, 1);
      tick();
      chk("t1_strobe", sel_strobe, 1);
      chk("t1_data", sel_data, t1d[k]);
      chk("t1_index", sel_index, k);
      chk("t1_count", entry_count, k + 1);
    end
    tick();
    chk("t1_strobe_low", sel_strobe, 0);

    // dwell 0 behaves as 1; change lands only at the next fetch
    dwell_len = 16'd0;
    wait_pop(20, n);
    chk("t2_old_len", n, 3);
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_pop(20, n);
      chk("t2_gap", n, 1);
      ed = mem[hd];
      ei = hd;
      tick();
      chk("t2_data", sel_data, ed);
      chk("t2_index", sel_index, ei);
    end
    chk("t2_count", entry_count, 7);

    // ring not ready for 10 cycles, re-init moves head to 40
    dwell_len = 16'd2;
    wait_pop(20, n);
    ed = mem[hd];
    tick();
    rdy = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      bcnt += int'(rif.ring_rd_en);
      reinit = (i == 5);
      reinit_val = 7'd40;
      tick();
    end
    reinit = 1'b0;
    chk("t3_no_pop", bcnt, 0);
    chk("t3_hold", sel_data, ed);
    rdy = 1'b1;
    #1;
    chk("t3_pop_now", rif.ring_rd_en, 1);
    tick();
    chk("t3_index", sel_index, 40);
    chk("t3_data", sel_data, mem[40]);

    // peek during dwell, valid on the 4th random-read cycle
    vmode = 1'b1;
    peek_addr = 7'h05;
    peek_req = 1'b1;
    tick();
    peek_req = 1'b0;
    chk("t4_rand_en", rif.ring_rand_rd_en, 1);
    chk("t4_busy", peek_busy, 1);
    chk("t4_addr", rif.ring_rand_rd_addr, 5);
    wait_done(20, n, ecnt, bcnt);
    chk("t4_done", peek_done, 1);
    chk("t4_err", peek_err, 0);
    chk("t4_data", peek_data, 4'h9);
    chk("t4_rand_low", rif.ring_rand_rd_en, 0);
    chk("t4_en_cycles", ecnt, 4);
    chk("t4_no_pop_busy", bcnt, 0);
    chk("t4_pop_after", rif.ring_rd_en, 1);
    tick();
    chk("t4_done_pulse", peek_done, 0);

    // peek request in a pop cycle: pop wins, random read next cycle
    wait_pop(20, n);
    peek_addr = 7'h11;
    peek_req = 1'b1;
    tick();
    peek_req = 1'b0;
    chk("t5_pop_first", rif.ring_rand_rd_en, 0);
    chk("t5_strobe", sel_strobe, 1);
    tick();
    chk("t5_rand_en", rif.ring_rand_rd_en, 1);
    chk("t5_addr", rif.ring_rand_rd_addr, 7'h11);
    wait_done(20, n, ecnt, bcnt);
    chk("t5_data", peek_data, 4'hC);

    // no valid: timeout after 255 random-read cycles
    vmode = 1'b0;
    peek_addr = 7'h03;
    peek_req = 1'b1;
    tick();
    peek_req = 1'b0;
    wait_done(400, n, ecnt, bcnt);
    chk("t6_done", peek_done, 1);
    chk("t6_err", peek_err, 1);
    chk("t6_en_cycles", ecnt + int'(rif.ring_rand_rd_en), 255);
    chk("t6_data_kept", peek_data, 4'hC);
    chk("t6_no_pop_busy", bcnt, 0);
    wait_pop(20, n);
    chk("t6_resume", rif.ring_rd_en, 1);
    tick();
    chk("t6_count", entry_count, pops);

    // enable low mid-dwell: finish and idle, last entry stays valid
    enable = 1'b0;
    p0 = pops;
    repeat (12) tick();
    chk("t7_no_pop", pops, p0);
    chk("t7_valid", sel_valid, 1);
    chk("t7_rd_en", rif.ring_rd_en, 0);

    chk("overlap", overlap, 0);
    chk("rd_not_ready", bad_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
